// File: rtl/wshb_fb_slave.sv
// wshb_fb_slave: Wishbone slave in front of an on-chip store of DEPTH 32-bit words.
// Define WSHB_FB_BURST_EN to enable incrementing (cti=010, bte=00) bursts.
// Without that macro, cti and bte are ignored and every request is a classic single beat.
//
// state   | meaning
// IDLE    | waiting for a request
// CLASSIC | single ack cycle; a latched write commits at its closing edge
// BURST   | incrementing burst, one beat per sampled cyc&stb
// ERROR   | one err cycle for an illegal request or a burst overrun
//
// Writes are always latched on the beat edge and committed on the next edge.
// Because the commit waits for that edge, cyc=0 or rst_n=0 during the ack cycle still drops the write.
// The memory therefore needs no reset gating of its own.
module wshb_fb_slave #(
    parameter int DEPTH = 1024,
    parameter int ADR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cyc,
    input  logic             stb,
    input  logic             we,
    input  logic [ADR_W-1:0] adr,
    input  logic [3:0]       sel,
    input  logic [31:0]      dat_ms,
    input  logic [2:0]       cti,
    input  logic [1:0]       bte,
    output logic [31:0]      dat_sm,
    output logic             ack,
    output logic             err
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = IW + 1;

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERROR} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_dat;
    logic          r_ack;
    logic          r_err;
    logic [PW-1:0] r_ptr;
    logic          r_wpend;
    logic [IW-1:0] r_widx;
    logic [31:0]   r_wdat;
    logic [3:0]    r_wsel;

    logic [ADR_W-3:0] w_widx;
    logic [IW-1:0]    w_idx;
    logic             w_oob;
    logic             w_illegal;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic [31:0]      w_dat_nxt;
    logic [PW-1:0]    w_ptr_nxt;
    logic             w_wpend_nxt;
    logic [IW-1:0]    w_wr_idx;
    logic             w_commit;
    logic             w_unused;

    assign w_widx = adr[ADR_W-1:2];
    assign w_idx  = w_widx[IW-1:0];
    assign w_oob  = (w_widx > (ADR_W-2)'(DEPTH - 1));

`ifdef WSHB_FB_BURST_EN
    assign w_illegal = w_oob | ((cti == 3'b010) & (bte != 2'b00));
    assign w_unused  = ^adr[1:0];
`else
    assign w_illegal = w_oob;
    assign w_unused  = ^{adr[1:0], cti, bte};
`endif

    // Next state plus the next values of the registered bus outputs and the write latch.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_nxt   = r_dat;
        w_ptr_nxt   = r_ptr;
        w_wpend_nxt = 1'b0;
        w_wr_idx    = w_idx;
        if (!cyc) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (stb) begin
                        if (w_illegal) begin
                            w_state_nxt = ERROR;
                            w_err_nxt   = 1'b1;
                        end
`ifdef WSHB_FB_BURST_EN
                        else if (cti == 3'b010) begin
                            w_state_nxt = BURST;
                            w_ack_nxt   = 1'b1;
                            w_dat_nxt   = r_mem[w_idx];
                            w_ptr_nxt   = {1'b0, w_idx} + PW'(1);
                            w_wpend_nxt = we;
                        end
`endif
                        else begin
                            w_state_nxt = CLASSIC;
                            w_ack_nxt   = 1'b1;
                            w_wpend_nxt = we;
                            if (!we) begin
                                w_dat_nxt = r_mem[w_idx];
                            end
                        end
                    end
                end
                BURST: begin
`ifdef WSHB_FB_BURST_EN
                    // r_ptr already names the word for the next beat, so data streams without a bubble.
                    if (stb) begin
                        if (r_ptr >= PW'(DEPTH)) begin
                            w_state_nxt = ERROR;
                            w_err_nxt   = 1'b1;
                        end else begin
                            w_ack_nxt   = 1'b1;
                            w_dat_nxt   = r_mem[r_ptr[IW-1:0]];
                            w_ptr_nxt   = r_ptr + PW'(1);
                            w_wpend_nxt = we;
                            w_wr_idx    = r_ptr[IW-1:0];
                            // The final ack cycle goes through CLASSIC, so the last write commits before any new request.
                            if (cti == 3'b111) begin
                                w_state_nxt = CLASSIC;
                            end
                        end
                    end
`else
                    w_state_nxt = IDLE;
`endif
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered ack/err/read data, the burst pointer, and the write latched on a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_ptr   <= '0;
            r_wpend <= 1'b0;
            r_widx  <= '0;
            r_wdat  <= '0;
            r_wsel  <= '0;
        end else begin
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_dat   <= w_dat_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wpend <= w_wpend_nxt;
            if (w_wpend_nxt) begin
                r_widx <= w_wr_idx;
                r_wdat <= dat_ms;
                r_wsel <= sel;
            end
        end
    end

    assign w_commit = r_wpend & cyc & ((r_state == CLASSIC) | (r_state == BURST));

    // Store write port; the store has no reset, so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wsel[i]) begin
                    r_mem[r_widx][8*i +: 8] <= r_wdat[8*i +: 8];
                end
            end
        end
    end

    assign dat_sm = r_dat;
    assign ack    = r_ack;
    assign err    = r_err;
endmodule

// File: tb/tb_wshb_fb_slave.sv
// Scoreboard bench for wshb_fb_slave: the driver pushes expected responses, and a negedge monitor pops and checks them.
module tb_wshb_fb_slave;
    localparam int DEPTH = 64;
    localparam int ADR_W = 32;
`ifdef WSHB_FB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];
    int          checks   = 0;
    int          failures = 0;
    int          cnt      = 0;

    wshb_fb_slave #(.DEPTH(DEPTH), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
        .sel(sel), .dat_ms(dat_ms), .cti(cti), .bte(bte),
        .dat_sm(dat_sm), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cnt);
        end
    endtask

    task automatic push_exp(input bit is_err, input bit chk_dat, input logic [31:0] d);
        exp_t e;
        e.is_err  = is_err;
        e.chk_dat = chk_dat;
        e.dat     = d;
        e.cyc     = cnt + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_write(input int unsigned idx, input logic [3:0] s, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    endtask

    // Monitor: every ack/err must match the oldest expected response, in kind, cycle and read data.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack_err_exclusive", {31'b0, ack & err}, 32'd0);
            if (ack || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_response: got ack=%0b err=%0b at cycle %0d, want none", ack, err, cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_is_err", {31'b0, err}, {31'b0, mon_e.is_err});
                    chk("resp_cycle", cnt, mon_e.cyc);
                    if (mon_e.chk_dat) chk("read_data", dat_sm, mon_e.dat);
                end
            end
        end
    end

    // Classic single beat; hold=1 leaves the request asserted for a back-to-back follow-up.
    task automatic classic(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic [2:0] c, input logic [1:0] b, input bit hold);
        int unsigned idx;
        idx = a >> 2;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_ms = d; cti = c; bte = b;
        if (idx >= DEPTH || (BURST_EN && c == 3'b010 && b != 2'b00)) begin
            push_exp(1'b1, 1'b0, 32'h0);
        end else begin
            push_exp(1'b0, !w, model[idx]);
            if (w) model_write(idx, s, d);
        end
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        if (!hold) begin
            cyc = 1'b0; stb = 1'b0;
            @(posedge clk); @(negedge clk);
        end
    endtask

    // Incrementing burst of n beats; stb drops for 2 cycles after beat gap_after.
    task automatic burst(input int start, input int n, input bit w, input int gap_after, input logic [1:0] b);
        bit          stop;
        int unsigned idx;
        stop = 1'b0;
        for (int k = 0; k < n && !stop; k++) begin
            idx    = start + k;
            cyc    = 1'b1; stb = 1'b1; we = w; sel = 4'hF; dat_ms = $urandom; bte = b;
            adr    = (k == 0) ? 32'(start * 4) : $urandom;
            cti    = (k == n - 1) ? 3'b111 : 3'b010;
            if (idx >= DEPTH || (k == 0 && b != 2'b00)) begin
                push_exp(1'b1, 1'b0, 32'h0);
                stop = 1'b1;
            end else begin
                push_exp(1'b0, !w, model[idx]);
                if (w) model[idx] = dat_ms;
            end
            @(posedge clk); @(negedge clk);
            if (k == gap_after) begin
                stb = 1'b0;
                @(posedge clk); @(negedge clk);
                @(posedge clk); @(negedge clk);
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        repeat (2) begin @(posedge clk); @(negedge clk); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra;
        int          r;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0;
        dat_ms = '0; cti = '0; bte = '0;
        #12;
        chk("reset_ack", {31'b0, ack}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_dat_sm", dat_sm, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the store so every read has a known expected value; the first request goes in on the first edge after reset.
        for (int i = 0; i < DEPTH; i++)
            classic(1'b1, 32'(i * 4), 4'hF, $urandom, 3'b000, 2'b00, 1'b1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);

        classic(1'b1, 32'h10, 4'hF, 32'hBABECAFE, 3'b000, 2'b00, 1'b0);
        classic(1'b0, 32'h10, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);
        classic(1'b1, 32'h0, 4'hF, 32'h11223344, 3'b000, 2'b00, 1'b0);
        classic(1'b1, 32'h0, 4'b0010, 32'hAAAAAAAA, 3'b000, 2'b00, 1'b0);
        classic(1'b0, 32'h0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);
        classic(1'b0, 32'(4 * DEPTH), 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);
        classic(1'b1, 32'(4 * DEPTH + 8), 4'hF, 32'h12345678, 3'b000, 2'b00, 1'b0);
        classic(1'b0, 32'h13, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);
        classic(1'b0, 32'h8, 4'hF, 32'h0, 3'b010, 2'b01, 1'b0);

        // A write whose cyc drops during the ack cycle must be discarded.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_ms = 32'hDEAD0001;
        cti = 3'b000; bte = 2'b00;
        push_exp(1'b0, 1'b0, 32'h0);
        @(posedge clk); @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); @(negedge clk);
        classic(1'b0, 32'h20, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);

        // Reset in the ack cycle of a write: ack drops at once and the write is suppressed.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h24; sel = 4'hF; dat_ms = 32'hDEAD0002;
        push_exp(1'b0, 1'b0, 32'h0);
        @(posedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ack", {31'b0, ack}, 32'd0);
        chk("async_reset_err", {31'b0, err}, 32'd0);
        chk("async_reset_dat_sm", dat_sm, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        classic(1'b0, 32'h24, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);

`ifdef WSHB_FB_BURST_EN
        for (int i = 0; i < 4; i++)
            classic(1'b1, 32'(i * 4), 4'hF, 32'(i), 3'b000, 2'b00, 1'b0);
        burst(0, 4, 1'b0, -1, 2'b00);
        burst(0, 4, 1'b0, 1, 2'b00);
        burst(8, 5, 1'b1, 2, 2'b00);
        burst(8, 5, 1'b0, -1, 2'b00);
        burst(DEPTH - 2, 4, 1'b0, -1, 2'b00);
        burst(0, 3, 1'b0, -1, 2'b01);
        classic(1'b0, 32'h4, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0);
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = 32'($urandom_range(0, DEPTH + 2) * 4 + $urandom_range(0, 3));
            if (BURST_EN) begin
                r  = $urandom_range(0, 2);
                rc = (r == 0) ? 3'b000 : (r == 1) ? 3'b111 : 3'b001;
            end else begin
                rc = 3'($urandom_range(0, 7));
            end
            classic(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom,
                    rc, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        chk("responses_outstanding", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
